angle_display_scan: RTL
=======================

ANGLE_DISPLAY_SCAN -- requirements
Module: angle_display_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000, meaning clock cycles each digit is driven before the scan advances (minimum 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port en  input  1  global enable; when low, all registers hold.
REQ-005 SHALL have port angle  input  9  unsigned angle in degrees from the processing unit.
REQ-006 SHALL have port angle_valid  input  1  angle is presented this cycle.
REQ-007 SHALL have port angle_ready  output  1  block can accept an angle (high only in IDLE).
REQ-008 SHALL have port seg  output  7  active-low segment pattern, bit0=a to bit6=g, registered.
REQ-009 SHALL have port an  output  3  active-low digit select, one-hot-low, bit0=units, bit2=hundreds, registered.

Function
REQ-010 SHALL implement the FSM states IDLE, CONV and UPD.
REQ-011 SHALL accept an angle at edge N when state=IDLE, en=1 and angle_valid=1: capture angle, go to CONV, clear the iteration count.
REQ-012 SHALL, in CONV, perform one shift-add-3 (double-dabble) iteration per enabled edge, nine in total (edges N+1..N+9), then go to UPD.
REQ-013 SHALL, in UPD (edge N+10), write the three BCD digits and the error flag to the display registers and return to IDLE.
REQ-014 SHALL have an accept-to-display latency of exactly 10 enabled cycles; angle_ready is low from N+1 through N+10.
REQ-015 SHALL drop, without effect, any angle_valid asserted while not in IDLE (no queueing).
REQ-016 SHALL set the error flag when the captured angle is greater than 359; with the flag set, all three digits show dash (7'b0111111).
REQ-017 SHALL blank leading zeros: hundreds blank when 0; tens blank when hundreds and tens are both 0; units never blank; blank = 7'b1111111.
REQ-018 SHALL have a refresh counter that counts 0..REFRESH_DIV-1 per enabled edge and, on wrap, advances the digit index 0->1->2->0.
REQ-019 SHALL update seg and an on the same edge as the digit index changes, so they are always coherent (no one-cycle mismatch).
REQ-020 SHALL make a display-register update in UPD visible on seg at the next edge, without waiting for a scan wrap.
REQ-021 SHALL, when en=0, freeze the FSM, the iteration count, the refresh counter and the outputs; an angle_valid while en=0 is ignored.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set: state IDLE, iteration count 0, refresh counter 0, digit index 0, display digits 0/0/0, error flag 0.
REQ-023 SHALL, after reset, drive an=3'b110, seg=7'b1000000 (units "0") and angle_ready=1.
REQ-024 SHALL abort a conversion in progress on reset mid-CONV/UPD without updating the display registers; rst has priority over en.

Structure
REQ-025 SHALL place the FSM state typedef, SEG_BLANK, SEG_DASH and ANGLE_MAX=359 in the shared package disp_pkg.
REQ-026 SHALL isolate the iterative converter in one sub-module bin2bcd_seq (start, 9-bit in, done, three 4-bit digits); scan and decode stay in the top level.

Verification
REQ-027 SHALL verify: reset, then idle 3*REFRESH_DIV cycles -> an cycles 110,101,011; seg 1000000 on units, 1111111 on tens and hundreds.
REQ-028 SHALL verify: angle=245 accepted at edge N -> angle_ready low N+1..N+10; digits 2/4/5 (seg 0100100, 0011001, 0010010) from N+11.
REQ-029 SHALL verify: angle=7 -> units 1111000; tens and hundreds blank. Then angle=40 -> hundreds blank, tens 0011001, units 1000000.
REQ-030 SHALL verify: angle=360 and angle=511 -> all digits 0111111. Then angle=359 -> 3/5/9 shown.
REQ-031 SHALL verify: angle_valid with 100 at N, then 200 at N+3 (busy) -> 100 displayed and 200 dropped; en=0 for 5 cycles mid-CONV -> latency extends by exactly 5.
REQ-032 SHALL verify: rst pulsed at N+5 of a conversion of 123 -> display remains "  0" and angle_ready=1 on the cycle after reset.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the angle display: FSM state encoding, special
// segment patterns, the largest displayable angle and the digit decoder.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    UPD  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [8:0] ANGLE_MAX = 9'd359;
  localparam int         BCD_ITERS = 9;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 9-bit binary to 3-digit BCD converter (double dabble), one
// add-3/shift iteration per enabled clock.
// Ports: clk, rst (sync, active-high), en (hold when low), start (load bin_in
// and clear the iteration count), bin_in[8:0], done (the current enabled
// edge completes the final iteration), bcd_h/bcd_t/bcd_u digit outputs.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [8:0] bin_in,
  output logic       done,
  output logic [3:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_u
);

  localparam logic [3:0] LAST_ITER = 4'(BCD_ITERS - 1);

  logic [8:0]  sh_q,   sh_d;
  logic [11:0] bcd_q,  bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic        busy_q, busy_d;
  logic [11:0] adj;

  always_comb begin
    adj = bcd_q;
    if (bcd_q[3:0]  >= 4'd5) adj[3:0]  = bcd_q[3:0]  + 4'd3;
    if (bcd_q[7:4]  >= 4'd5) adj[7:4]  = bcd_q[7:4]  + 4'd3;
    if (bcd_q[11:8] >= 4'd5) adj[11:8] = bcd_q[11:8] + 4'd3;

    sh_d   = sh_q;
    bcd_d  = bcd_q;
    iter_d = iter_q;
    busy_d = busy_q;
    if (start) begin
      sh_d   = bin_in;
      bcd_d  = '0;
      iter_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, sh_d} = {adj[10:0], sh_q, 1'b0};
      iter_d        = iter_q + 4'd1;
      if (iter_q == LAST_ITER) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else if (en) begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end

  assign done  = busy_q && (iter_q == LAST_ITER);
  assign bcd_h = bcd_q[11:8];
  assign bcd_t = bcd_q[7:4];
  assign bcd_u = bcd_q[3:0];

endmodule

// File: rtl/angle_display_scan.sv
// Accepts a 9-bit angle, converts it to BCD and drives a 3-digit multiplexed
// 7-segment display with leading-zero blanking and an out-of-range dash mode.
// Ports: clk, rst (sync, active-high), en (global hold when low), angle[8:0],
// angle_valid, angle_ready (high in IDLE), seg[6:0] (active-low, bit0=a),
// an[2:0] (active-low digit select, bit0=units).
module angle_display_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [8:0] angle,
  input  logic       angle_valid,
  output logic       angle_ready,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int           RW       = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  state_e        state_q, state_d;
  logic          err_cap_q, err_cap_d;
  logic [3:0]    disp_h_q, disp_h_d, disp_t_q, disp_t_d, disp_u_q, disp_u_d;
  logic          err_q, err_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    dig_idx_q, dig_idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic          conv_start, conv_done;
  logic [3:0]    bcd_h, bcd_t, bcd_u;
  logic [6:0]    seg_h, seg_t, seg_u;
  logic          ref_wrap;

  // The converter is itself gated by en, so an angle_valid while en=0
  // starts nothing.
  assign conv_start = (state_q == IDLE) && angle_valid;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (conv_start),
    .bin_in (angle),
    .done   (conv_done),
    .bcd_h  (bcd_h),
    .bcd_t  (bcd_t),
    .bcd_u  (bcd_u)
  );

  always_comb begin
    state_d   = state_q;
    err_cap_d = err_cap_q;
    disp_h_d  = disp_h_q;
    disp_t_d  = disp_t_q;
    disp_u_d  = disp_u_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (angle_valid) begin
          state_d   = CONV;
          err_cap_d = (angle > ANGLE_MAX);
        end
      end
      CONV: begin
        if (conv_done) state_d = UPD;
      end
      UPD: begin
        disp_h_d = bcd_h;
        disp_t_d = bcd_t;
        disp_u_d = bcd_u;
        err_d    = err_cap_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode uses the current display registers, so a UPD write shows up on
  // seg one enabled edge later regardless of where the scan is.
  always_comb begin
    seg_u = err_q ? SEG_DASH : seg_of_digit(disp_u_q);
    seg_t = err_q ? SEG_DASH :
            ((disp_h_q == 4'd0) && (disp_t_q == 4'd0)) ? SEG_BLANK : seg_of_digit(disp_t_q);
    seg_h = err_q ? SEG_DASH :
            (disp_h_q == 4'd0) ? SEG_BLANK : seg_of_digit(disp_h_q);

    ref_wrap  = (ref_cnt_q == REF_LAST);
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RW'(1);
    dig_idx_d = dig_idx_q;
    if (ref_wrap) dig_idx_d = (dig_idx_q == 2'd2) ? 2'd0 : dig_idx_q + 2'd1;

    // seg and an both follow the next digit index so they never disagree.
    case (dig_idx_d)
      2'd0:    begin an_d = 3'b110; seg_d = seg_u; end
      2'd1:    begin an_d = 3'b101; seg_d = seg_t; end
      default: begin an_d = 3'b011; seg_d = seg_h; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      err_cap_q <= 1'b0;
      disp_h_q  <= '0;
      disp_t_q  <= '0;
      disp_u_q  <= '0;
      err_q     <= 1'b0;
      ref_cnt_q <= '0;
      dig_idx_q <= '0;
      seg_q     <= 7'b1000000;
      an_q      <= 3'b110;
    end else if (en) begin
      state_q   <= state_d;
      err_cap_q <= err_cap_d;
      disp_h_q  <= disp_h_d;
      disp_t_q  <= disp_t_d;
      disp_u_q  <= disp_u_d;
      err_q     <= err_d;
      ref_cnt_q <= ref_cnt_d;
      dig_idx_q <= dig_idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign angle_ready = (state_q == IDLE);
  assign seg         = seg_q;
  assign an          = an_q;

endmodule
